sr_frame_ctrl: RTL and testbench

Receive-side sequencer for the serial-to-parallel shift register (`stp_sr_N_lsb` family). It watches an idle-high serial line, detects and qualifies a start bit, and issues one `shift_enable` pulse per data bit at the bit centre. It checks the stop bit, then pulses `load_buffer` so the downstream buffer captures the shift register's `parallel_out`. It sits between the line pad and the shift register. The shift register's `serial_in` is driven from this block's `sync_out`, so data and enable are cycle-aligned.

---
 rtl/sr_frame_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_sr_frame_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_frame_ctrl.sv
// sr_frame_ctrl: receive-side sequencer for the stp_sr_N_lsb shift register.
//
// Watches an idle-high serial line, qualifies the start bit at its centre and
// emits one shift_enable pulse per data bit at the bit centre. It then checks
// the stop bit and pulses load_buffer so the downstream buffer captures the
// shift register's parallel_out. The shift register's serial_in must be fed
// from sync_out so that data and enable line up on the same cycle.
//
// Parameters:
//   DATA_BITS  data bits per frame (1..16), equal to the shift register size
//   BIT_PERIOD clock cycles per serial bit (even, >= 4)
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   serial_in     raw serial line, idle high
//   data_read     consumer took the word; clears data_ready / overrun_error
//   sync_out      2-FF synchronised serial_in
//   shift_enable  one-cycle pulse per data bit
//   load_buffer   one-cycle pulse, valid frame held in the shift register
//   data_ready    buffered word pending
//   framing_error last frame had a zero stop bit
//   overrun_error frame loaded while data_ready was already set
//   parity_error  even-parity mismatch on last frame (0 without the macro)
//   busy          any state other than idle
//
// Build option: define SR_FRAME_PARITY_EN to add one even-parity bit after the
// data bits. Without it there is no parity state and parity_error is tied 0.

module sr_frame_ctrl #(
  parameter int unsigned DATA_BITS  = 4,
  parameter int unsigned BIT_PERIOD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  input  logic data_read,
  output logic sync_out,
  output logic shift_enable,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
  output logic parity_error,
  output logic busy
);

  localparam int unsigned CntW  = $clog2(BIT_PERIOD);
  localparam int unsigned BitsW = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0]  CntHalf  = CntW'(BIT_PERIOD / 2 - 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(BIT_PERIOD - 1);
  localparam logic [BitsW-1:0] BitsLast = BitsW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef SR_FRAME_PARITY_EN
    StParity,
`endif
    StStop,
    StLoad
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [BitsW-1:0] bits_q, bits_d;
  logic             sync_meta_q, sync_q, sync_prev_q;
  logic             framing_q, framing_d;
  logic             data_ready_q, data_ready_d;
  logic             overrun_q, overrun_d;
  logic             frame_ok;

`ifdef SR_FRAME_PARITY_EN
  logic par_acc_q, par_acc_d;
  logic par_bad_q, par_bad_d;
  logic parity_error_q, parity_error_d;
`endif

  // Synchroniser plus one history flop for falling-edge detection. All reset
  // to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_q <= 1'b1;
      sync_q      <= 1'b1;
      sync_prev_q <= 1'b1;
    end else begin
      sync_meta_q <= serial_in;
      sync_q      <= sync_meta_q;
      sync_prev_q <= sync_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bits_q       <= '0;
      framing_q    <= 1'b0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bits_q       <= bits_d;
      framing_q    <= framing_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef SR_FRAME_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_acc_q      <= 1'b0;
      par_bad_q      <= 1'b0;
      parity_error_q <= 1'b0;
    end else begin
      par_acc_q      <= par_acc_d;
      par_bad_q      <= par_bad_d;
      parity_error_q <= parity_error_d;
    end
  end

  assign frame_ok = !framing_q && !par_bad_q;
`else
  assign frame_ok = !framing_q;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bits_d       = bits_q;
    framing_d    = framing_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    shift_enable = 1'b0;
    load_buffer  = 1'b0;
`ifdef SR_FRAME_PARITY_EN
    par_acc_d      = par_acc_q;
    par_bad_d      = par_bad_q;
    parity_error_d = parity_error_q;
`endif

    // Consumer acknowledge may arrive in any cycle; a load below overrides it.
    if (data_read) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (sync_prev_q && !sync_q) begin
          state_d   = StStart;
          cnt_d     = '0;
          framing_d = 1'b0;
`ifdef SR_FRAME_PARITY_EN
          parity_error_d = 1'b0;
          par_bad_d      = 1'b0;
`endif
        end
      end

      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!sync_q) begin
            state_d = StData;
            bits_d  = '0;
`ifdef SR_FRAME_PARITY_EN
            par_acc_d = 1'b0;
`endif
          end else begin
            // Line bounced back high before mid-bit: not a real start bit.
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (cnt_q == CntLast) begin
          shift_enable = 1'b1;
          cnt_d        = '0;
          bits_d       = bits_q + BitsW'(1);
`ifdef SR_FRAME_PARITY_EN
          par_acc_d = par_acc_q ^ sync_q;
`endif
          if (bits_q == BitsLast) begin
`ifdef SR_FRAME_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

`ifdef SR_FRAME_PARITY_EN
      StParity: begin
        if (cnt_q == CntLast) begin
          // Even parity: data ones plus parity bit must be even.
          par_bad_d = par_acc_q ^ sync_q;
          cnt_d     = '0;
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif

      StStop: begin
        if (cnt_q == CntLast) begin
          framing_d = !sync_q;
          cnt_d     = '0;
          state_d   = StLoad;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StLoad: begin
        state_d = StIdle;
`ifdef SR_FRAME_PARITY_EN
        parity_error_d = par_bad_q;
`endif
        if (frame_ok) begin
          load_buffer  = 1'b1;
          data_ready_d = 1'b1;
          if (data_ready_q && !data_read) begin
            overrun_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign sync_out      = sync_q;
  assign data_ready    = data_ready_q;
  assign framing_error = framing_q;
  assign overrun_error = overrun_q;
  assign busy          = (state_q != StIdle);
`ifdef SR_FRAME_PARITY_EN
  assign parity_error  = parity_error_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_sr_frame_ctrl.sv
// Directed bench for sr_frame_ctrl (DATA_BITS=4, BIT_PERIOD=10). A small model
// of the LSB-first shift register is clocked by the DUT's shift_enable and
// sync_out so the loaded word can be checked.

module tb_sr_frame_ctrl;

  localparam int unsigned Db = 4;
  localparam int unsigned Bp = 10;
`ifdef SR_FRAME_PARITY_EN
  localparam int unsigned Pb = 1;
`else
  localparam int unsigned Pb = 0;
`endif

  logic tb_clk = 1'b0;
  logic rst;
  logic serial_in;
  logic data_read;
  logic sync_out;
  logic shift_enable;
  logic load_buffer;
  logic data_ready;
  logic framing_error;
  logic overrun_error;
  logic parity_error;
  logic busy;

  int total = 0;
  int bad   = 0;

  sr_frame_ctrl #(
    .DATA_BITS (Db),
    .BIT_PERIOD(Bp)
  ) dut (
    .clk          (tb_clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .data_read    (data_read),
    .sync_out     (sync_out),
    .shift_enable (shift_enable),
    .load_buffer  (load_buffer),
    .data_ready   (data_ready),
    .framing_error(framing_error),
    .overrun_error(overrun_error),
    .parity_error (parity_error),
    .busy         (busy)
  );

  always #5 tb_clk = ~tb_clk;

  int cyc = 0;
  always @(posedge tb_clk) cyc <= cyc + 1;

  // Downstream shift register: new bit enters at the MSB, so the first
  // received bit ends up in bit 0.
  logic [Db-1:0] sr_model;
  always @(posedge tb_clk) begin
    if (shift_enable) sr_model <= {sync_out, sr_model[Db-1:1]};
  end

  // Pulse / busy event recorder, sampled mid-cycle.
  int se_t[256];
  int ld_t[256];
  int se_n = 0;
  int ld_n = 0;
  logic [Db-1:0] cap;
  logic busy_seen = 1'b0;
  int busy_rise = -1;
  int busy_fall = -1;

  always @(negedge tb_clk) begin
    if (shift_enable === 1'b1) begin
      if (se_n < 256) se_t[se_n] = cyc;
      se_n++;
    end
    if (load_buffer === 1'b1) begin
      if (ld_n < 256) ld_t[ld_n] = cyc;
      ld_n++;
      cap = sr_model;
    end
    if (busy === 1'b1 && !busy_seen) busy_rise = cyc;
    if (busy !== 1'b1 && busy_seen) busy_fall = cyc;
    busy_seen = (busy === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge tb_clk);
      #1;
    end
  endtask

  // Drives idle gap, start, data LSB first, optional parity, stop. t0 is the
  // cycle in which the DUT sees the falling edge on sync_out.
  task automatic send_frame(input logic [Db-1:0] data, input logic stop, input logic par_flip,
                            input logic dr, output int t0);
    int ld;
    serial_in = 1'b1;
    data_read = 1'b0;
    tick(4);
    t0 = cyc + 2;
    ld = t0 + Bp / 2 + (Db + 1 + Pb) * Bp + 1;
    serial_in = 1'b0;
    tick(Bp);
    for (int k = 0; k < Db; k++) begin
      serial_in = data[k];
      tick(Bp);
    end
`ifdef SR_FRAME_PARITY_EN
    serial_in = (^data) ^ par_flip;
    tick(Bp);
`else
    if (par_flip) serial_in = 1'b0;
`endif
    serial_in = stop;
    for (int i = 0; i < Bp; i++) begin
      data_read = (cyc == ld) ? dr : 1'b0;
      tick(1);
    end
    data_read = 1'b0;
    serial_in = 1'b1;
    tick(4);
  endtask

  task automatic check_frame(input string tag, input int t0, input int se_base, input int ld_base,
                             input logic exp_load, input logic [Db-1:0] exp_data);
    int ld;
    ld = t0 + Bp / 2 + (Db + 1 + Pb) * Bp + 1;
    check({tag, "_se_count"}, se_n - se_base, Db);
    for (int k = 0; k < Db; k++) begin
      if (se_base + k < 256) begin
        check({tag, "_se_time"}, se_t[se_base + k], t0 + Bp / 2 + (k + 1) * Bp);
      end
    end
    check({tag, "_busy_rise"}, busy_rise, t0 + 1);
    check({tag, "_busy_fall"}, busy_fall, ld + 1);
    if (exp_load) begin
      check({tag, "_ld_count"}, ld_n - ld_base, 1);
      if (ld_base < 256) check({tag, "_ld_time"}, ld_t[ld_base], ld);
      check({tag, "_word"}, cap, exp_data);
    end else begin
      check({tag, "_ld_count"}, ld_n - ld_base, 0);
    end
  endtask

  initial begin
    int t0;
    int se_b;
    int ld_b;

    rst       = 1'b1;
    serial_in = 1'b1;
    data_read = 1'b0;
    tick(3);
    check("rst_sync_out", sync_out, 1);
    check("rst_busy", busy, 0);
    check("rst_data_ready", data_ready, 0);
    check("rst_flags", {framing_error, overrun_error, parity_error}, 0);
    check("rst_pulses", {shift_enable, load_buffer}, 0);
    rst = 1'b0;
    tick(3);

    // Frame A: bits 1,0,1,0 -> word 0101.
    se_b = se_n; ld_b = ld_n;
    send_frame(4'b0101, 1'b1, 1'b0, 1'b0, t0);
    check_frame("a", t0, se_b, ld_b, 1'b1, 4'b0101);
    check("a_data_ready", data_ready, 1);
    check("a_overrun", overrun_error, 0);
    check("a_framing", framing_error, 0);
    check("a_parity", parity_error, 0);

    // Frame B without a read in between -> overrun.
    se_b = se_n; ld_b = ld_n;
    send_frame(4'b0011, 1'b1, 1'b0, 1'b0, t0);
    check_frame("b", t0, se_b, ld_b, 1'b1, 4'b0011);
    check("b_data_ready", data_ready, 1);
    check("b_overrun", overrun_error, 1);

    // Standalone read clears both.
    data_read = 1'b1;
    tick(1);
    data_read = 1'b0;
    check("rd_data_ready", data_ready, 0);
    check("rd_overrun", overrun_error, 0);

    // Frame C into an empty buffer.
    se_b = se_n; ld_b = ld_n;
    send_frame(4'b1001, 1'b1, 1'b0, 1'b0, t0);
    check_frame("c", t0, se_b, ld_b, 1'b1, 4'b1001);
    check("c_data_ready", data_ready, 1);
    check("c_overrun", overrun_error, 0);

    // Frame D with data_read in the LOAD cycle: no overrun, still ready.
    se_b = se_n; ld_b = ld_n;
    send_frame(4'b0110, 1'b1, 1'b0, 1'b1, t0);
    check_frame("d", t0, se_b, ld_b, 1'b1, 4'b0110);
    check("d_data_ready", data_ready, 1);
    check("d_overrun", overrun_error, 0);

    // Frame E with a zero stop bit: no load, buffer flags untouched.
    se_b = se_n; ld_b = ld_n;
    send_frame(4'b1010, 1'b0, 1'b0, 1'b0, t0);
    check_frame("e", t0, se_b, ld_b, 1'b0, 4'b0000);
    check("e_framing", framing_error, 1);
    check("e_data_ready", data_ready, 1);
    check("e_overrun", overrun_error, 0);

    // Frame F: new start clears framing_error; buffer still full -> overrun.
    se_b = se_n; ld_b = ld_n;
    send_frame(4'b1111, 1'b1, 1'b0, 1'b0, t0);
    check_frame("f", t0, se_b, ld_b, 1'b1, 4'b1111);
    check("f_framing", framing_error, 0);
    check("f_data_ready", data_ready, 1);
    check("f_overrun", overrun_error, 1);

    // Glitch: line low for 3 cycles only.
    serial_in = 1'b1;
    tick(4);
    se_b = se_n; ld_b = ld_n;
    t0 = cyc + 2;
    serial_in = 1'b0;
    tick(3);
    serial_in = 1'b1;
    tick(30);
    check("glitch_se_count", se_n - se_b, 0);
    check("glitch_ld_count", ld_n - ld_b, 0);
    check("glitch_busy_rise", busy_rise, t0 + 1);
    check("glitch_busy_fall", busy_fall, t0 + 6);
    check("glitch_busy", busy, 0);

    // Reset in the middle of the data bits with the line low.
    serial_in = 1'b1;
    tick(4);
    t0 = cyc + 2;
    serial_in = 1'b0;
    tick(22);
    check("mid_busy", busy, 1);
    se_b = se_n; ld_b = ld_n;
    rst = 1'b1;
    #1;
    check("mrst_sync_out", sync_out, 1);
    check("mrst_busy", busy, 0);
    check("mrst_outputs", {shift_enable, load_buffer, data_ready, framing_error,
                           overrun_error, parity_error}, 0);
    serial_in = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(70);
    check("mrst_se_count", se_n - se_b, 0);
    check("mrst_ld_count", ld_n - ld_b, 0);
    check("mrst_idle", busy, 0);

`ifdef SR_FRAME_PARITY_EN
    // Bits 1,1,0,0 with parity 1 (odd total): rejected.
    se_b = se_n; ld_b = ld_n;
    send_frame(4'b0011, 1'b1, 1'b1, 1'b0, t0);
    check_frame("pbad", t0, se_b, ld_b, 1'b0, 4'b0000);
    check("pbad_parity", parity_error, 1);
    check("pbad_data_ready", data_ready, 0);
    // Same bits with parity 0: loaded at t0+66.
    se_b = se_n; ld_b = ld_n;
    send_frame(4'b0011, 1'b1, 1'b0, 1'b0, t0);
    check_frame("pok", t0, se_b, ld_b, 1'b1, 4'b0011);
    check("pok_ld_abs", ld_t[ld_b], t0 + 66);
    check("pok_parity", parity_error, 0);
    check("pok_data_ready", data_ready, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
